// File: rtl/room_navigator.sv
// -----------------------------------------------------------------------------
// room_navigator
//   Tracks the player's on-screen position and current room once per video
//   frame. Feeds mapX/mapY to map_generator and playerX/playerY to the
//   sprite/compositor stage. A wall hit reported during active video makes the
//   next frame revert to the previously committed position.
//
//   Frame flow: IDLE -(VBlank rise)-> STEP -> EDGE -> COMMIT -> IDLE.
//   The outputs update on the 3rd clk_vga edge after the frame-tick edge and
//   then hold for the rest of the frame.
//
// Ports
//   clk_vga     in   VGA pixel clock
//   reset       in   synchronous, active-low reset
//   VBlank      in   vertical blank; its rising edge is the frame tick
//   btnUp/Down  in   vertical move requests (Up decreases playerY)
//   btnLeft/Right in horizontal move requests
//   wallHit     in   player/wall pixel overlap from the compositor
//   mapX/mapY   out  current room coordinates (4 bits each)
//   playerX     out  player top-left X (10 bits)
//   playerY     out  player top-left Y (9 bits)
//   roomChange  out  one-cycle pulse when mapX/mapY changed
//
// Build option
//   ROOM_TABLE_CHECK_EN : when defined, a screen-edge crossing only changes
//   room if the destination is in the fixed legal-room table; otherwise the
//   player is clamped at that edge. Undefined: any room 0..15 is accepted.
// -----------------------------------------------------------------------------
module room_navigator #(
    parameter int START_X     = 3,
    parameter int START_Y     = 4,
    parameter int STEP        = 2,
    parameter int PLAYER_SIZE = 8,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480
) (
    input  logic       clk_vga,
    input  logic       reset,
    input  logic       VBlank,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       wallHit,
    output logic [3:0] mapX,
    output logic [3:0] mapY,
    output logic [9:0] playerX,
    output logic [8:0] playerY,
    output logic       roomChange
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STEP   = 2'd1;
    localparam logic [1:0] S_EDGE   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - PLAYER_SIZE);
    localparam logic signed [10:0] Y_MAX   = 11'(SCREEN_H - PLAYER_SIZE);
    // Entry coordinate when arriving from the opposite side of the screen.
    localparam logic signed [10:0] X_ENTER = 11'(SCREEN_W - PLAYER_SIZE - STEP);
    localparam logic signed [10:0] Y_ENTER = 11'(SCREEN_H - PLAYER_SIZE - STEP);
    localparam logic [9:0]         RST_PX  = 10'(SCREEN_W / 2 - PLAYER_SIZE / 2);
    localparam logic [8:0]         RST_PY  = 9'(SCREEN_H / 2 - PLAYER_SIZE / 2);

    logic [1:0]         state_q, state_d;
    logic               vblank_q;
    logic               hit_q, hit_d;
    logic [3:0]         mapx_q, mapx_d, mapy_q, mapy_d;
    logic [9:0]         px_q, px_d, prevx_q, prevx_d;
    logic [8:0]         py_q, py_d, prevy_q, prevy_d;
    logic               rc_q, rc_d;
    // STEP -> EDGE pipeline: signed candidate position and revert marker.
    logic signed [10:0] candx_q, candx_d, candy_q, candy_d;
    logic               revert_q, revert_d;
    // EDGE -> COMMIT pipeline: resolved position and room.
    logic [9:0]         resx_q, resx_d;
    logic [8:0]         resy_q, resy_d;
    logic [3:0]         resmx_q, resmx_d, resmy_q, resmy_d;

    logic signed [10:0] cur_x, cur_y, dx, dy;
    logic               x_lo, x_hi, y_lo, y_hi;
    logic [3:0]         tgt_mx, tgt_my;
    logic               x_legal, y_legal, x_ok, y_ok;
    logic [8:0]         y_clamped;

    assign cur_x = $signed({1'b0, px_q});
    assign cur_y = $signed({2'b00, py_q});

    // Opposite buttons on one axis cancel.
    always_comb begin
        dx = 11'sd0;
        dy = 11'sd0;
        if (btnRight && !btnLeft)      dx = STEP_S;
        else if (btnLeft && !btnRight) dx = -STEP_S;
        if (btnDown && !btnUp)         dy = STEP_S;
        else if (btnUp && !btnDown)    dy = -STEP_S;
    end

    assign x_lo = candx_q < 11'sd0;
    assign x_hi = candx_q > X_MAX;
    assign y_lo = candy_q < 11'sd0;
    assign y_hi = candy_q > Y_MAX;

    // Leaving through the top goes north, which is mapY+1.
    assign tgt_mx = x_lo ? mapx_q - 4'd1 : mapx_q + 4'd1;
    assign tgt_my = y_lo ? mapy_q + 4'd1 : mapy_q - 4'd1;

`ifdef ROOM_TABLE_CHECK_EN
    function automatic logic room_legal(input logic [3:0] rx, input logic [3:0] ry);
        case ({rx, ry})
            8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16,
            8'h24, 8'h25, 8'h26,
            8'h34, 8'h35, 8'h36,
            8'h46, 8'h47:  room_legal = 1'b1;
            default:       room_legal = 1'b0;
        endcase
    endfunction
    assign x_legal = room_legal(tgt_mx, mapy_q);
    assign y_legal = room_legal(mapx_q, tgt_my);
`else
    assign x_legal = 1'b1;
    assign y_legal = 1'b1;
`endif

    // A revert candidate is always on-screen, but the explicit term keeps
    // revert frames from ever changing room.
    assign x_ok = !revert_q && x_legal && (x_lo ? (mapx_q != 4'd0) : (mapx_q != 4'hF));
    assign y_ok = !revert_q && y_legal && (y_lo ? (mapy_q != 4'hF) : (mapy_q != 4'd0));

    assign y_clamped = y_lo ? 9'd0 : (y_hi ? Y_MAX[8:0] : candy_q[8:0]);

    always_comb begin
        state_d  = state_q;
        hit_d    = hit_q | (wallHit & ~VBlank);
        mapx_d   = mapx_q;
        mapy_d   = mapy_q;
        px_d     = px_q;
        py_d     = py_q;
        prevx_d  = prevx_q;
        prevy_d  = prevy_q;
        rc_d     = 1'b0;
        candx_d  = candx_q;
        candy_d  = candy_q;
        revert_d = revert_q;
        resx_d   = resx_q;
        resy_d   = resy_q;
        resmx_d  = resmx_q;
        resmy_d  = resmy_q;

        case (state_q)
            S_IDLE: begin
                if (VBlank && !vblank_q) state_d = S_STEP;
            end
            S_STEP: begin
                revert_d = hit_q;
                if (hit_q) begin
                    candx_d = $signed({1'b0, prevx_q});
                    candy_d = $signed({2'b00, prevy_q});
                end else begin
                    candx_d = cur_x + dx;
                    candy_d = cur_y + dy;
                end
                state_d = S_EDGE;
            end
            S_EDGE: begin
                resmx_d = mapx_q;
                resmy_d = mapy_q;
                resx_d  = candx_q[9:0];
                resy_d  = candy_q[8:0];
                if (x_lo || x_hi) begin
                    // X crossing takes priority; Y just stays on screen.
                    resy_d = y_clamped;
                    if (x_ok) begin
                        resmx_d = tgt_mx;
                        resx_d  = x_lo ? X_ENTER[9:0] : STEP_S[9:0];
                    end else begin
                        resx_d  = x_lo ? 10'd0 : X_MAX[9:0];
                    end
                end else if (y_lo || y_hi) begin
                    if (y_ok) begin
                        resmy_d = tgt_my;
                        resy_d  = y_lo ? Y_ENTER[8:0] : STEP_S[8:0];
                    end else begin
                        resy_d  = y_clamped;
                    end
                end
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                mapx_d = resmx_q;
                mapy_d = resmy_q;
                px_d   = resx_q;
                py_d   = resy_q;
                // On a revert the new position equals prev, so prev is left
                // as-is: a second consecutive hit then holds the position.
                if (!revert_q) begin
                    prevx_d = px_q;
                    prevy_d = py_q;
                end
                rc_d    = (resmx_q != mapx_q) || (resmy_q != mapy_q);
                hit_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_vga) begin
        // Tracked through reset so a VBlank already high at release is not
        // mistaken for a fresh frame tick.
        vblank_q <= VBlank;
        if (!reset) begin
            state_q  <= S_IDLE;
            hit_q    <= 1'b0;
            mapx_q   <= 4'(START_X);
            mapy_q   <= 4'(START_Y);
            px_q     <= RST_PX;
            py_q     <= RST_PY;
            prevx_q  <= RST_PX;
            prevy_q  <= RST_PY;
            rc_q     <= 1'b0;
            candx_q  <= 11'sd0;
            candy_q  <= 11'sd0;
            revert_q <= 1'b0;
            resx_q   <= RST_PX;
            resy_q   <= RST_PY;
            resmx_q  <= 4'(START_X);
            resmy_q  <= 4'(START_Y);
        end else begin
            state_q  <= state_d;
            hit_q    <= hit_d;
            mapx_q   <= mapx_d;
            mapy_q   <= mapy_d;
            px_q     <= px_d;
            py_q     <= py_d;
            prevx_q  <= prevx_d;
            prevy_q  <= prevy_d;
            rc_q     <= rc_d;
            candx_q  <= candx_d;
            candy_q  <= candy_d;
            revert_q <= revert_d;
            resx_q   <= resx_d;
            resy_q   <= resy_d;
            resmx_q  <= resmx_d;
            resmy_q  <= resmy_d;
        end
    end

    assign mapX       = mapx_q;
    assign mapY       = mapy_q;
    assign playerX    = px_q;
    assign playerY    = py_q;
    assign roomChange = rc_q;

endmodule

// File: tb/tb_room_navigator.sv
// Bench for room_navigator: directed scenarios plus a random walk, checked
// against a frame-level behavioural model of player position and room.
module tb_room_navigator;

    logic       clk_vga = 1'b0;
    logic       reset   = 1'b0;
    logic       VBlank  = 1'b0;
    logic       btnUp = 1'b0, btnDown = 1'b0, btnLeft = 1'b0, btnRight = 1'b0;
    logic       wallHit = 1'b0;
    logic [3:0] mapX, mapY;
    logic [9:0] playerX;
    logic [8:0] playerY;
    logic       roomChange;

    int vecs = 0;
    int errs = 0;

    // Model state (plain integers, one update per frame).
    int m_px, m_py, m_mx, m_my, m_prx, m_pry, m_rc;

    // Observations from the last frame: before tick, 2 edges after, 3 edges after.
    logic [27:0] o_pre, o_e2, o_st;
    logic        o_rc_after;
    logic [3:0]  s_mx, s_my;
    logic [9:0]  s_px;
    logic [8:0]  s_py;
    logic        s_rc;

    localparam logic [27:0] RSTV = {4'd3, 4'd4, 10'd316, 9'd236, 1'b0};

    room_navigator dut (
        .clk_vga(clk_vga), .reset(reset), .VBlank(VBlank),
        .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft), .btnRight(btnRight),
        .wallHit(wallHit), .mapX(mapX), .mapY(mapY),
        .playerX(playerX), .playerY(playerY), .roomChange(roomChange)
    );

    always #5 clk_vga = ~clk_vga;

    function automatic logic [27:0] outs();
        return {mapX, mapY, playerX, playerY, roomChange};
    endfunction

    function automatic logic [27:0] expv();
        return {4'(m_mx), 4'(m_my), 10'(m_px), 9'(m_py), 1'(m_rc)};
    endfunction

    function automatic bit legal(input int x, input int y);
`ifdef ROOM_TABLE_CHECK_EN
        int code;
        code = x * 16 + y;
        return code inside {'h11, 'h12, 'h13, 'h14, 'h15, 'h16, 'h24, 'h25,
                            'h26, 'h34, 'h35, 'h36, 'h46, 'h47};
`else
        return (x >= 0) && (y >= 0);
`endif
    endfunction

    task automatic model_reset();
        m_px = 316; m_py = 236; m_mx = 3; m_my = 4;
        m_prx = 316; m_pry = 236; m_rc = 0;
    endtask

    task automatic model_frame(input int u, input int d, input int l, input int r, input int h);
        int cx, cy, t, omx, omy;
        omx = m_mx; omy = m_my;
        if (h != 0) begin
            m_px = m_prx; m_py = m_pry;
        end else begin
            cx = m_px + 2 * (r - l);
            cy = m_py + 2 * (d - u);
            m_prx = m_px; m_pry = m_py;
            if (cx < 0 || cx > 632) begin
                t = (cx < 0) ? m_mx - 1 : m_mx + 1;
                if (t >= 0 && t <= 15 && legal(t, m_my)) begin
                    m_mx = t; m_px = (cx < 0) ? 630 : 2;
                end else m_px = (cx < 0) ? 0 : 632;
                m_py = (cy < 0) ? 0 : (cy > 472) ? 472 : cy;
            end else if (cy < 0 || cy > 472) begin
                t = (cy < 0) ? m_my + 1 : m_my - 1;
                if (t >= 0 && t <= 15 && legal(m_mx, t)) begin
                    m_my = t; m_py = (cy < 0) ? 470 : 2;
                end else m_py = (cy < 0) ? 0 : 472;
                m_px = cx;
            end else begin
                m_px = cx; m_py = cy;
            end
        end
        m_rc = (m_mx != omx || m_my != omy) ? 1 : 0;
    endtask

    // Drives one frame: active video (optional wall hit), VBlank rise, and
    // samples outputs around the commit edge.
    task automatic run_frame(input int u, input int d, input int l, input int r, input int h);
        btnUp = (u != 0); btnDown = (d != 0); btnLeft = (l != 0); btnRight = (r != 0);
        repeat (2) @(posedge clk_vga);
        if (h != 0) begin
            @(posedge clk_vga); #1 wallHit = 1'b1;
            @(posedge clk_vga); #1 wallHit = 1'b0;
        end
        @(posedge clk_vga); #1;
        VBlank = 1'b1;
        o_pre = outs();
        repeat (3) @(posedge clk_vga);
        #1 o_e2 = outs();
        @(posedge clk_vga);
        #1 o_st = outs();
        s_mx = mapX; s_my = mapY; s_px = playerX; s_py = playerY; s_rc = roomChange;
        @(posedge clk_vga);
        #1 o_rc_after = roomChange;
        VBlank = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk_vga);
        #1;
        vecs++;
        if (outs() !== RSTV) begin
            errs++; $display("FAIL reset_values got=%h want=%h", outs(), RSTV);
        end
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_vga);
        #1;
        vecs++;
        if (outs() !== RSTV) begin
            errs++; $display("FAIL reset_idle_hold got=%h want=%h", outs(), RSTV);
        end
    endtask

    task automatic test_step_right();
        model_frame(0, 0, 0, 1, 0);
        run_frame(0, 0, 0, 1, 0);
        vecs++;
        if (o_e2 !== o_pre) begin
            errs++; $display("FAIL step_latency_early got=%h want=%h", o_e2, o_pre);
        end
        vecs++;
        if (s_px !== 10'd318 || s_mx !== 4'd3 || s_rc !== 1'b0) begin
            errs++; $display("FAIL step_right got x=%0d mx=%0d rc=%0b want x=318 mx=3 rc=0",
                             s_px, s_mx, s_rc);
        end
        vecs++;
        if (o_st !== expv()) begin
            errs++; $display("FAIL step_model got=%h want=%h", o_st, expv());
        end
    endtask

    task automatic test_wall_revert();
        model_frame(0, 0, 0, 0, 1);
        run_frame(0, 0, 0, 0, 1);
        vecs++;
        if (s_px !== 10'd316 || s_py !== 9'd236 || s_rc !== 1'b0 || o_rc_after !== 1'b0) begin
            errs++; $display("FAIL wall_revert got x=%0d y=%0d rc=%0b want x=316 y=236 rc=0",
                             s_px, s_py, s_rc);
        end
        // Second consecutive hit, direction ignored: position holds.
        model_frame(0, 0, 0, 1, 1);
        run_frame(0, 0, 0, 1, 1);
        vecs++;
        if (s_px !== 10'd316 || o_st !== expv()) begin
            errs++; $display("FAIL wall_hold got x=%0d st=%h want x=316 st=%h", s_px, o_st, expv());
        end
    endtask

    task automatic test_reset_mid_edge();
        model_frame(0, 0, 0, 1, 0);
        run_frame(0, 0, 0, 1, 0);
        vecs++;
        if (o_st !== expv()) begin
            errs++; $display("FAIL pre_reset_move got=%h want=%h", o_st, expv());
        end
        btnRight = 1'b1;
        @(posedge clk_vga); #1 VBlank = 1'b1;
        @(posedge clk_vga);          // tick -> STEP
        @(posedge clk_vga);          // STEP -> EDGE
        #1 reset = 1'b0;
        @(posedge clk_vga);          // reset sampled while in EDGE
        #1;
        vecs++;
        if (outs() !== RSTV) begin
            errs++; $display("FAIL reset_in_edge got=%h want=%h", outs(), RSTV);
        end
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_vga); #1;
            vecs++;
            if (outs() !== RSTV) begin
                errs++; $display("FAIL reset_no_commit cyc=%0d got=%h want=%h", i, outs(), RSTV);
            end
        end
        VBlank = 1'b0;
        btnRight = 1'b0;
        model_frame(0, 0, 0, 1, 0);
        run_frame(0, 0, 0, 1, 0);
        vecs++;
        if (o_st !== expv()) begin
            errs++; $display("FAIL post_reset_frame got=%h want=%h", o_st, expv());
        end
    endtask

    // Walks (3,4) -> (3,5) -> (3,6) -> (4,6) -> (4,7), then pushes right.
    task automatic test_room_walk();
        int dir_up[5] = '{1, 1, 0, 1, 0};
        int u, r, n;
        for (int leg = 0; leg < 5; leg++) begin
            u = dir_up[leg]; r = 1 - u; n = 0;
            while (n < 600) begin
                if (leg == 4 && m_px == 632) break;
                model_frame(u, 0, 0, r, 0);
                run_frame(u, 0, 0, r, 0);
                n++;
                vecs++;
                if (o_st !== expv() || o_e2 !== o_pre || o_rc_after !== 1'b0) begin
                    errs++; $display("FAIL walk leg=%0d got=%h e2=%h rc_after=%0b want=%h",
                                     leg, o_st, o_e2, o_rc_after, expv());
                end
                if (leg == 1 && m_rc == 1) begin
                    vecs++;
                    if (o_pre[9:1] !== 9'd0 || s_my !== 4'd6 || s_py !== 9'd470 ||
                        s_rc !== 1'b1 || o_rc_after !== 1'b0) begin
                        errs++; $display("FAIL north_cross got my=%0d y=%0d rc=%0b/%0b want my=6 y=470 rc=1/0",
                                         s_my, s_py, s_rc, o_rc_after);
                    end
                end
                if (leg < 4 && m_rc == 1) break;
            end
            if (n >= 600) begin
                vecs++; errs++;
                $display("FAIL walk_timeout leg=%0d frames=%0d", leg, n);
            end
        end
        model_frame(0, 0, 0, 1, 0);
        run_frame(0, 0, 0, 1, 0);
        vecs++;
`ifdef ROOM_TABLE_CHECK_EN
        if (s_mx !== 4'd4 || s_my !== 4'd7 || s_px !== 10'd632 || s_rc !== 1'b0) begin
            errs++; $display("FAIL east_blocked got mx=%0d my=%0d x=%0d want mx=4 my=7 x=632", s_mx, s_my, s_px);
        end
`else
        if (s_mx !== 4'd5 || s_my !== 4'd7 || s_px !== 10'd2 || s_rc !== 1'b1) begin
            errs++; $display("FAIL east_cross got mx=%0d my=%0d x=%0d want mx=5 my=7 x=2", s_mx, s_my, s_px);
        end
`endif
    endtask

    task automatic test_random();
        int u, d, l, r, h;
        for (int i = 0; i < 150; i++) begin
            u = int'($urandom_range(0, 1)); d = int'($urandom_range(0, 1));
            l = int'($urandom_range(0, 1)); r = int'($urandom_range(0, 1));
            h = ($urandom_range(0, 4) == 0) ? 1 : 0;
            model_frame(u, d, l, r, h);
            run_frame(u, d, l, r, h);
            vecs++;
            if (o_st !== expv() || o_e2 !== o_pre || o_rc_after !== 1'b0) begin
                errs++; $display("FAIL random i=%0d btn=%0d%0d%0d%0d hit=%0d got=%h want=%h",
                                 i, u, d, l, r, h, o_st, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_step_right();
        test_wall_revert();
        test_reset_mid_edge();
        test_room_walk();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
